ahb_apb_bridge_gen2: RTL

Parametrised AHB-to-APB3 bridge, the successor to the fixed 3-slave Bridge_Top.
Widths, slave count and address map are generic, and it adds APB3 wait states (Pready) and slave errors (Pslverr).
A programmable Pready timeout aborts hung accesses, and unmapped addresses are decoded to an AHB ERROR response.
It sits between the AHB master and the APB peripheral segment and handles one transfer at a time (no write posting).

---
 rtl/ahb_apb_bridge_gen2.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ahb_apb_bridge_gen2.sv
// AHB-to-APB3 bridge with a single transfer in flight, generic slave map, APB wait
// states, slave errors and a Pready timeout; unmapped addresses get a two-cycle ERROR.
module ahb_apb_bridge_gen2 #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_SLAVES  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    REGION_LOG2 = 26,
  parameter int                    TIMEOUT     = 16
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic                  Hwrite,
  input  logic                  Hreadyin,
  input  logic [1:0]            Htrans,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  output logic [DATA_WIDTH-1:0] Hrdata,
  output logic                  Hreadyout,
  output logic [1:0]            Hresp,
  input  logic [DATA_WIDTH-1:0] Prdata,
  input  logic                  Pready,
  input  logic                  Pslverr,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic [DATA_WIDTH-1:0] Pwdata,
  output logic                  Pwrite,
  output logic                  Penable,
  output logic [NUM_SLAVES-1:0] Pselx
);

  localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TAG_LSB  = REGION_LOG2 + SEL_BITS;
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [SEL_BITS-1:0]     idx, idx_q;
  logic                    valid, accept, hit, timed_out;
  logic                    hready_d, penable_d, sel_phase;
  logic [1:0]              hresp_d;
  logic [NUM_SLAVES-1:0]   psel_d;

  // BUSY and IDLE transfer types are ignored; only NONSEQ/SEQ start an access.
  assign valid     = Hreadyin && (Htrans == 2'b10 || Htrans == 2'b11);
  assign accept    = valid && (state == IDLE || state == ERR2);
  assign idx       = Haddr[TAG_LSB-1:REGION_LOG2];
  assign hit       = (Haddr[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB]) &&
                     ({1'b0, idx} < (SEL_BITS+1)'(NUM_SLAVES));
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state     <= IDLE;
      cnt       <= '0;
      Hreadyout <= 1'b1;
      Hresp     <= 2'b00;
      Pselx     <= '0;
      Penable   <= 1'b0;
    end else begin
      state     <= state_next;
      Hreadyout <= hready_d;
      Hresp     <= hresp_d;
      Pselx     <= psel_d;
      Penable   <= penable_d;
      if (state == SETUP)
        cnt <= '0;
      else if (state == ACCESS && !Pready)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ERR2: begin
        if (valid) state_next = hit ? LATCH : ERR1;
        else       state_next = IDLE;
      end
      LATCH:  state_next = SETUP;
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (Pready)         state_next = Pslverr ? ERR1 : IDLE;
        else if (timed_out) state_next = ERR1;
      end
      ERR1:    state_next = ERR2;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they are registered.
  always_comb begin
    hready_d  = (state_next == IDLE) || (state_next == ERR2);
    hresp_d   = ((state_next == ERR1) || (state_next == ERR2)) ? 2'b01 : 2'b00;
    sel_phase = (state_next == SETUP) || (state_next == ACCESS);
    penable_d = (state_next == ACCESS);
    psel_d    = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      psel_d[i] = sel_phase && (idx_q == SEL_BITS'(i));
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Paddr  <= '0;
      Pwrite <= 1'b0;
      Pwdata <= '0;
      Hrdata <= '0;
      idx_q  <= '0;
    end else begin
      if (accept && hit) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        idx_q  <= idx;
      end
      // Hwdata arrives in the AHB data phase, which is the LATCH cycle.
      if (state == LATCH && Pwrite)
        Pwdata <= Hwdata;
      if (state == ACCESS && Pready && !Pslverr && !Pwrite)
        Hrdata <= Prdata;
    end
  end

endmodule
